// File: rtl/basics_pkg.sv
// Shared definitions for the basics library: FSM state encoding and default widths.
package basics_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/down_count_timer_if.sv
// Control/status bundle for down_count_timer: the controller drives start/period/mode,
// the timer returns its registered count and status flags.
interface down_count_timer_if #(
  parameter int WIDTH = basics_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             reload;
  logic             halt;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output start, load_val, reload, halt,
    input  count, busy, tc, done
  );

  modport slave (
    input  start, load_val, reload, halt,
    output count, busy, tc, done
  );

endinterface

// File: rtl/down_cnt_core.sv
// Count register with load mux (external value or stored period) and a modulo
// decrementer; flags count==1 so the controller can act on the terminal edge.
module down_cnt_core #(
  parameter int WIDTH = basics_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic             sel_reload,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] count,
  output logic             is_one
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // 0 - 1 wraps to all-ones, which is what gives load_val=0 its 2^WIDTH period
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = sel_reload ? period : load_val;
    end else if (dec) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign is_one = (count_q == WIDTH'(1));

endmodule

// File: rtl/down_count_timer.sv
// Loadable down-counter/timer: IDLE/RUN/DONE control, period register and
// registered tc/done/busy flags around the down_cnt_core datapath.
module down_count_timer
  import basics_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic               clk,
  input logic               reset,
  down_count_timer_if.slave bus
);

  state_e           state_d, state_q;
  logic [WIDTH-1:0] period_d, period_q;
  logic             tc_d, tc_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             load, dec, sel_reload;
  logic             is_one;
  logic [WIDTH-1:0] count;

  down_cnt_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .dec        (dec),
    .sel_reload (sel_reload),
    .load_val   (bus.load_val),
    .period     (period_q),
    .count      (count),
    .is_one     (is_one)
  );

  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    tc_d       = 1'b0;
    load       = 1'b0;
    dec        = 1'b0;
    sel_reload = 1'b0;
    case (state_q)
      RUN: begin
        // start outranks halt and the terminal edge, so a retrigger never emits tc
        if (bus.start) begin
          load     = 1'b1;
          period_d = bus.load_val;
        end else if (!bus.halt) begin
          if (is_one && bus.reload) begin
            load       = 1'b1;
            sel_reload = 1'b1;
            tc_d       = 1'b1;
          end else begin
            dec = 1'b1;
            if (is_one) begin
              tc_d    = 1'b1;
              state_d = DONE;
            end
          end
        end
      end
      default: begin
        if (bus.start) begin
          load     = 1'b1;
          period_d = bus.load_val;
          state_d  = RUN;
        end
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      period_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.count = count;
  assign bus.tc    = tc_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: doc/down_count_timer.md
# down_count_timer

Synchronous, loadable, programmable down-counter/timer for the basics library. It counts the complementary direction to the library's toggle-flip-flop up-counters and is fully synchronous, with no rippled clocks. Software or a controlling FSM loads a period and starts it. The block then decrements once per enabled cycle and flags terminal count, either as one-shot or as a periodic auto-reload. It is intended as the tick/timeout source for the other basics blocks.

## Interface
Parameters:
- WIDTH, 4, counter and period width in bits.

Ports:
- clk, in, 1: single clock; all state changes on posedge clk.
- reset, in, 1: synchronous, active-high; sampled on posedge clk.
- start, in, 1: single-cycle request to load `load_val` and begin counting.
- load_val, in, WIDTH: period; 0 encodes 2^WIDTH.
- reload, in, 1: 1 = periodic (auto-reload) mode; 0 = one-shot. Sampled at every terminal-count edge.
- halt, in, 1: pause; while high in RUN, `count` holds.
- count, out, WIDTH: current count value (registered).
- busy, out, 1: high in RUN, including while halted.
- tc, out, 1: registered terminal-count pulse, exactly one cycle wide.
- done, out, 1: level; high in DONE until `start` or `reset`.

## Operation
- FSM states are IDLE, RUN and DONE.
- Reset values: state=IDLE, count=0, period register=0, busy=0, tc=0, done=0.
- Priority within a cycle: reset > start > halt > decrement.
- IDLE or DONE with start=1:
  - count <= load_val; period register <= load_val.
  - Next state RUN, busy=1, done=0.
- RUN with start=1 (retrigger):
  - Reload from `load_val` and stay in RUN.
  - No tc is produced on that edge, even if count==1.
- RUN, start=0, halt=1: count, state and period register all hold; tc=0.
- RUN, start=0, halt=0:
  - count != 1: count <= count-1, modulo 2^WIDTH, so 0 wraps to all-ones. This implements the 2^WIDTH period for load_val=0.
  - count == 1 and reload=1: count <= period register; stay in RUN; tc=1 for the next cycle.
  - count == 1 and reload=0: count <= 0; state <= DONE; tc=1 for the next cycle; done=1.
- DONE: count holds at 0; busy=0; done=1 until start or reset.
- IDLE and DONE ignore halt and reload.
- Reset mid-RUN returns all outputs to reset values on that edge. No tc is produced, even if count==1.

## Timing
- Start latency: start sampled at edge k gives count=load_val and busy=1 after edge k.
- Period: with no halt, tc is high in the cycle after edge k+N, where N = load_val (or 2^WIDTH when load_val=0).
- Periodic mode: tc repeats every N cycles with no gap cycle.
- Halt: each halted cycle extends the period by exactly one cycle.
- Output registering: tc, done, busy and count are all registered, with no combinational path from any input to any output.
- One-shot termination: done rises in the same cycle as tc; busy falls in that cycle.

## Structure
- Shared package `basics_pkg` holds:
  - the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), as a typedef or localparams;
  - the default WIDTH constant.
- One sub-module, `down_cnt_core`, holds the count register, the load mux (load_val / period register) and the modulo decrementer. Its controls are load, dec and sel_reload; it outputs count and is_one.
- Top level holds the FSM, the period register and the tc/done/busy registers.

## Test plan
- One-shot:
  - Stimulus: reset, then start with load_val=5, reload=0.
  - Required: count reads 5,4,3,2,1,0; tc high for exactly one cycle, 5 cycles after the start edge; done=1 and busy=0 from then on; count holds at 0.
- Periodic:
  - Stimulus: load_val=3, reload=1.
  - Required: count reads 3,2,1,3,2,1,…; tc pulses every 3 cycles for at least 4 periods.
  - Then drop reload: the next terminal count goes to DONE with count=0.
- Zero period:
  - Stimulus: WIDTH=4, load_val=0.
  - Required: count reads 0,15,14,…,1; tc fires exactly 16 cycles after start.
- Halt and retrigger:
  - Stimulus: load_val=4, halt for 2 cycles while count=2.
  - Required: tc is delayed by exactly 2 cycles.
  - Retrigger: start with load_val=6 while count=1 gives no tc, and count=6 on the next cycle.
- Reset:
  - Stimulus: assert reset while count=1 in RUN.
  - Required: no tc; count=0, busy=0, done=0 on the next cycle; a subsequent start behaves normally.
